// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution unit.
package cond_pkg;

    // ARM condition field encodings.
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flags vector.
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // Branch-shadow squash states.
    typedef enum logic {
        RUN  = 1'b0,
        SHAD = 1'b1
    } shad_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition check: Cond x NZCV -> cond_ok.
// Kept standalone so the branch predictor check can reuse it.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       cond_ok
);

    logic n, z, c, v;

    assign n = Flags[N_IDX];
    assign z = Flags[Z_IDX];
    assign c = Flags[C_IDX];
    assign v = Flags[V_IDX];

    // Decode the condition field; the reserved 1111 encoding never passes.
    always_comb begin
        cond_ok = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = ~z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = ~c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = ~n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = ~v;
            COND_HI: cond_ok = c & ~z;
            COND_LS: cond_ok = ~c | z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = ~z & (n == v);
            COND_LE: cond_ok = z | (n != v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_pipe.sv
// Execute-stage conditional unit: NZCV flags, write gating, branch-shadow
// squashing and a saved-flags register for exception entry/return.
module cond_unit_pipe
    import cond_pkg::*;
#(
    parameter int SHADOW  = 2,
    parameter int EN_SAVE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Valid,
    input  logic       Stall,
    input  logic       Flush,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       FlagSave,
    input  logic       FlagRestore,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       ShadowActive,
    output logic [3:0] Flags
);

    // Counter must hold SHADOW; keep at least one bit when squashing is off.
    localparam int CNT_W = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;

    logic [3:0]       flags_q, flags_d;
    logic [3:0]       saved_q, saved_d;
    shad_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cond_ok;
    logic             live;
    logic             save_en, restore_en;

    cond_eval u_cond_eval (
        .Cond    (Cond),
        .Flags   (flags_q),
        .cond_ok (cond_ok)
    );

    // Slot gating: only ALUFlags-free terms reach the outputs.
    assign ShadowActive = (state_q == SHAD) & ~reset;
    assign live         = Valid & ~Stall & ~Flush & ~ShadowActive & ~reset;
    assign CondEx       = cond_ok & live;
    assign RegWrite     = RegW & CondEx;
    assign MemWrite     = MemW & CondEx;
    assign PCSrc        = PCS & CondEx;
    assign Flags        = flags_q;

    // Save/restore follow the pipeline freeze only, independent of kill.
    assign save_en    = (EN_SAVE != 0) & FlagSave & ~Stall;
    assign restore_en = (EN_SAVE != 0) & FlagRestore & ~Stall;

    // Next flags and saved values; restore overrides any ALU flag write.
    always_comb begin
        flags_d = flags_q;
        saved_d = saved_q;
        if (CondEx && FlagW[1]) begin
            flags_d[N_IDX] = ALUFlags[N_IDX];
            flags_d[Z_IDX] = ALUFlags[Z_IDX];
        end
        if (CondEx && FlagW[0]) begin
            flags_d[C_IDX] = ALUFlags[C_IDX];
            flags_d[V_IDX] = ALUFlags[V_IDX];
        end
        if (save_en) begin
            saved_d = flags_q;
        end
        if (restore_en) begin
            flags_d = saved_q;
        end
    end

    // Flags and saved-flags registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
            saved_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
            saved_q <= saved_d;
        end
    end

    // Branch-shadow FSM: counts squashed slots, so stalls hold the count.
    always_ff @(posedge clk) begin
        if (reset || Flush) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (PCSrc && (SHADOW > 0)) begin
                        state_q <= SHAD;
                        cnt_q   <= CNT_W'(SHADOW);
                    end
                end
                SHAD: begin
                    if (!Stall) begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Scoreboard bench for cond_unit_pipe: directed plan followed by random traffic.
module tb_cond_unit_pipe;

    localparam int SHADOW = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Valid = 1'b0, Stall = 1'b0, Flush = 1'b0;
    logic [3:0] Cond = 4'h0, ALUFlags = 4'h0;
    logic [1:0] FlagW = 2'b00;
    logic       PCS = 1'b0, RegW = 1'b0, MemW = 1'b0;
    logic       FlagSave = 1'b0, FlagRestore = 1'b0;
    logic       PCSrc, RegWrite, MemWrite, CondEx, ShadowActive;
    logic [3:0] Flags;

    cond_unit_pipe #(.SHADOW(SHADOW), .EN_SAVE(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .Valid        (Valid),
        .Stall        (Stall),
        .Flush        (Flush),
        .Cond         (Cond),
        .ALUFlags     (ALUFlags),
        .FlagW        (FlagW),
        .PCS          (PCS),
        .RegW         (RegW),
        .MemW         (MemW),
        .FlagSave     (FlagSave),
        .FlagRestore  (FlagRestore),
        .PCSrc        (PCSrc),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .CondEx       (CondEx),
        .ShadowActive (ShadowActive),
        .Flags        (Flags)
    );

    always #5 clk = ~clk;

    // Expected {PCSrc,RegWrite,MemWrite,CondEx,ShadowActive,Flags[3:0]} per cycle.
    logic [8:0] sb[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference state: architectural flags, saved copy, squash slots still owed.
    bit [3:0] m_flags = 4'b0;
    bit [3:0] m_saved = 4'b0;
    int       m_left  = 0;

    function automatic bit m_cond(input int c, input bit [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cf;
            3:  return !cf;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cf && !z;
            9:  return !cf || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Apply one cycle of inputs, predict this cycle's outputs, advance the model.
    task automatic step(input bit v, input bit st, input bit fl, input bit [3:0] c,
                        input bit [3:0] al, input bit [1:0] fw, input bit pcs,
                        input bit rw, input bit mw, input bit sv, input bit rs,
                        input bit rst);
        bit sa, lv, cx;
        bit [3:0] nf, ns;
        @(posedge clk);
        #1;
        Valid = v; Stall = st; Flush = fl; Cond = c; ALUFlags = al; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; FlagSave = sv; FlagRestore = rs; reset = rst;

        sa = !rst && (m_left > 0);
        lv = v && !st && !fl && !sa && !rst;
        cx = lv && m_cond(int'(c), m_flags);
        sb.push_back({pcs && cx, rw && cx, mw && cx, cx, sa, m_flags});

        if (rst) begin
            m_flags = 4'b0;
            m_saved = 4'b0;
            m_left  = 0;
        end else begin
            nf = m_flags;
            ns = m_saved;
            if (cx && fw[1]) nf[3:2] = al[3:2];
            if (cx && fw[0]) nf[1:0] = al[1:0];
            if (sv && !st) ns = m_flags;
            if (rs && !st) nf = m_saved;
            if (fl)            m_left = 0;
            else if (sa)       m_left = st ? m_left : m_left - 1;
            else if (cx && pcs) m_left = SHADOW;
            m_flags = nf;
            m_saved = ns;
        end
    endtask

    // Monitor: compare DUT outputs against the oldest prediction, mid-cycle.
    always @(negedge clk) begin
        logic [8:0] exp_v, act_v;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            act_v = {PCSrc, RegWrite, MemWrite, CondEx, ShadowActive, Flags};
            total_cnt++;
            if (act_v !== exp_v)
                $display("FAIL outputs t=%0t got {pc,rw,mw,cx,sa,nzcv}=%b required %b",
                         $time, act_v, exp_v);
            else
                pass_cnt++;
        end
    end

    initial begin
        // reset
        step(0,0,0,4'h0,4'h0,2'b00,0,0,0,0,0,1);
        step(0,0,0,4'h0,4'h0,2'b00,0,0,0,0,0,1);
        // flag write then EQ / NE
        step(1,0,0,4'hE,4'b0100,2'b11,0,0,0,0,0,0);
        step(1,0,0,4'h0,4'h0,2'b00,0,1,0,0,0,0);
        step(1,0,0,4'h1,4'h0,2'b00,0,1,0,0,0,0);
        // partial writes
        step(1,0,0,4'hE,4'b0000,2'b11,0,0,0,0,0,0);
        step(1,0,0,4'hE,4'b1111,2'b10,0,0,0,0,0,0);
        step(1,0,0,4'hE,4'b1111,2'b01,0,0,0,0,0,0);
        step(1,0,0,4'hE,4'h0,2'b00,0,0,1,0,0,0);
        // shadow without stall
        step(1,0,0,4'hE,4'h0,2'b00,1,1,0,0,0,0);
        for (int i = 0; i < 3; i++) step(1,0,0,4'hE,4'h0,2'b00,0,1,0,0,0,0);
        // shadow with a stall in the first slot
        step(1,0,0,4'hE,4'h0,2'b00,1,1,0,0,0,0);
        step(1,1,0,4'hE,4'h0,2'b00,0,1,0,0,0,0);
        for (int i = 0; i < 3; i++) step(1,0,0,4'hE,4'h0,2'b00,0,1,0,0,0,0);
        // flush inside shadow
        step(1,0,0,4'hE,4'h0,2'b00,1,1,0,0,0,0);
        step(1,0,1,4'hE,4'h0,2'b00,0,1,0,0,0,0);
        step(1,0,0,4'hE,4'h0,2'b00,0,1,0,0,0,0);
        // save / restore / swap
        step(1,0,0,4'hE,4'b1010,2'b11,0,0,0,0,0,0);
        step(0,0,0,4'h0,4'h0,2'b00,0,0,0,1,0,0);
        step(1,0,0,4'hE,4'b0101,2'b11,0,0,0,0,0,0);
        step(1,0,0,4'hE,4'b0000,2'b11,0,0,0,0,1,0);
        step(1,0,0,4'hE,4'b0011,2'b11,0,0,0,0,0,0);
        step(0,0,0,4'h0,4'h0,2'b00,0,0,0,1,1,0);
        step(0,0,0,4'h0,4'h0,2'b00,0,0,0,0,1,0);
        // reserved condition, stall gating
        step(1,0,0,4'hF,4'b1111,2'b11,1,1,1,0,0,0);
        step(1,1,0,4'hE,4'b1111,2'b11,1,1,1,0,0,0);
        step(1,0,0,4'hE,4'h0,2'b00,0,0,0,0,0,0);
        // reset mid-shadow
        step(1,0,0,4'hE,4'b1001,2'b11,1,0,0,0,0,0);
        step(1,0,0,4'hE,4'h0,2'b00,0,1,0,0,0,1);
        step(1,0,0,4'hE,4'h0,2'b00,0,1,0,0,0,0);
        step(1,0,0,4'hE,4'h0,2'b00,0,1,0,0,0,0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0,9) < 8, $urandom_range(0,6) == 0,
                 $urandom_range(0,24) == 0, 4'($urandom_range(0,15)),
                 4'($urandom), 2'($urandom), $urandom_range(0,4) == 0,
                 1'($urandom), 1'($urandom), $urandom_range(0,9) == 0,
                 $urandom_range(0,9) == 0, $urandom_range(0,99) == 0);
        end
        // let the monitor drain, bounded
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            total_cnt++;
            $display("FAIL drain pending=%0d required 0", sb.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cond_unit_pipe.md
# cond_unit_pipe

Pipelined successor of the processor's conditional-execution unit. It sits in the Execute stage of the pipelined ARM-subset core. It holds the NZCV flags register and evaluates each instruction's 4-bit condition field. It gates the register, memory and PC writes, and adds stall/flush handling, a branch-shadow squash state machine and a saved-flags register for exception entry and return.

## Interface
- `SHADOW`, default 2: number of Execute slots squashed after a taken branch; 0 disables squashing.
- `EN_SAVE`, default 1: 1 instantiates the saved-flags register; 0 ties `FlagSave`/`FlagRestore` off internally.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Valid` in 1: Execute stage holds a real instruction.
- `Stall` in 1: Execute is frozen this cycle.
- `Flush` in 1: kill the Execute instruction and abort any shadow.
- `Cond` in 4: instruction condition field.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU.
- `FlagW` in 2: [1] writes N,Z; [0] writes C,V.
- `PCS`, `RegW`, `MemW` in 1 each: decoder write requests.
- `FlagSave`, `FlagRestore` in 1 each: copy Flags to Saved, or Saved to Flags.
- `PCSrc`, `RegWrite`, `MemWrite` out 1 each: gated writes.
- `CondEx` out 1: condition passed and instruction live.
- `ShadowActive` out 1: current slot is squashed by branch shadow.
- `Flags` out 4: architectural NZCV.

## Operation
- `cond_ok` = evaluation of `Cond` against the registered `Flags`, using the standard ARM encodings:
  - EQ/NE, CS/CC, MI/PL, VS/VC, HI/LS, GE/LT, GT/LE, AL.
  - GE is N==V.
  - 4'b1111 gives 0; never X.
- `live` = Valid & ~Stall & ~Flush & ~ShadowActive & ~reset.
- `CondEx` = `cond_ok` & `live`.
- `RegWrite` = RegW & CondEx; `MemWrite` = MemW & CondEx; `PCSrc` = PCS & CondEx.
- Flags update at the edge, only when CondEx is 1:
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1].
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0].
  - Groups are independent.
- Saved register, active only when `EN_SAVE`=1:
  - Save and restore are gated by ~Stall only; not by Flush, CondEx or shadow.
  - FlagSave: Saved <= current (pre-update) Flags.
  - FlagRestore: Flags <= Saved. Overrides any FlagW update in the same cycle.
  - Save and restore in the same cycle swap the two registers.
- Shadow FSM has states RUN and SHAD, with counter `cnt` of width max(1, $clog2(SHADOW+1)).
  - RUN -> SHAD when PCSrc=1 and SHADOW>0; cnt <= SHADOW.
  - In SHAD, ShadowActive=1. Each cycle with ~Stall decrements cnt. When cnt==1 and not stalled, go to RUN.
  - Stall in SHAD holds cnt, so squashing is counted in pipeline slots, not cycles.
  - Flush in any state forces RUN, cnt=0. Flush has priority over a same-cycle branch, which cannot occur anyway because Flush kills CondEx.
  - An instruction in a shadow slot can never branch; no re-entry is possible from SHAD.
- Reset, synchronous:
  - Flags=0, Saved=0, state RUN, cnt=0.
  - While reset is high, all write outputs and CondEx are 0 and ShadowActive=0.

## Timing
- `CondEx`, `PCSrc`, `RegWrite`, `MemWrite` and `ShadowActive` are combinational from the current inputs and registered state.
  - Zero-cycle latency.
  - No combinational path from ALUFlags to any output.
- Flag writes are visible to `Flags` and `cond_ok` on the cycle after the writing instruction; there is no same-cycle forwarding.
- The first shadow slot is the cycle after the PCSrc=1 edge. With SHADOW=N and no stalls, exactly N cycles have ShadowActive=1.
- Reset asserted mid-shadow aborts the shadow at the next edge.

## Structure
- Package `cond_pkg`:
  - `cond_e` enum of the 16 condition codes.
  - Flag index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
  - `shad_state_e` {RUN, SHAD}.
- Sub-module `cond_eval`: purely combinational `Cond` x `Flags` -> `cond_ok`, reusable by the branch predictor check.
- Flags, Saved and the FSM live in `cond_unit_pipe` itself.

## Test plan
- Flag write and condition check:
  - Reset, then Valid, Cond=AL, FlagW=11, ALUFlags=0100 -> next cycle Flags=0100.
  - Then Cond=EQ, RegW=1 -> CondEx=1, RegWrite=1.
  - Then Cond=NE -> RegWrite=0.
- Partial flag write: Flags=0000, FlagW=10, ALUFlags=1111 -> Flags=1100. Then FlagW=01 -> Flags=1111.
- Branch shadow, SHADOW=2:
  - Taken PCS at cycle t (Cond=AL) -> PCSrc=1 at t.
  - ShadowActive=1 and RegWrite=0 with RegW=1 at t+1 and t+2; RegWrite=1 at t+3.
  - Repeat with Stall at t+1 -> squashed slots extend to t+3, RegWrite=1 at t+4.
- Flush at t+1 of a shadow -> ShadowActive=0 at t+2; the instruction at t+1 is killed.
- Save/restore:
  - Flags=1010, FlagSave; later Flags updated to 0101.
  - FlagRestore with FlagW=11, ALUFlags=0000, CondEx=1 -> Flags=1010 (restore wins).
  - Simultaneous save+restore swaps Flags and Saved.
- Edge cases:
  - Cond=1111 -> CondEx=0.
  - Stall=1 with Cond=AL, FlagW=11 -> all writes 0 and Flags unchanged.
  - Reset mid-shadow -> RUN next cycle, Flags=0.
